// File: rtl/cordic_ci_ctrl.sv
// cordic_ci_ctrl: sequencer for the CORDIC custom instruction.
// The datapath order is unpacker -> sdiv -> iterative core -> packer.
// This block accepts one float32 operand through the Nios II multi-cycle
// handshake. It then steps through conversion, core init, the iteration loop
// and output packing, and returns the packed result with a one-cycle done pulse.
// It contains control logic only and no arithmetic.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   clk_en       advance when high; when low, all state and outputs freeze
//   start/dataa  request and float32 operand, sampled in IDLE only
//   done/result  one-cycle done pulse; result holds until the next capture
//   busy         high in every state except IDLE
//   op_data      latched operand that feeds the unpacker
//   init         one-cycle pulse: the core loads the sdiv output
//   iter_en      the core performs one iteration this cycle
//   iter_idx     iteration index (shift amount / atan LUT address)
//   pk_result    packer output, captured on the last PACK edge
module cordic_ci_ctrl #(
  parameter int CONV_LAT   = 1,
  parameter int ITERATIONS = 22,
  parameter int PACK_LAT   = 1,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [31:0]      dataa,
  output logic             done,
  output logic [31:0]      result,
  output logic             busy,
  output logic [31:0]      op_data,
  output logic             init,
  output logic             iter_en,
  output logic [IDX_W-1:0] iter_idx,
  input  logic [31:0]      pk_result
);

  // One counter is shared by CONV and PACK, so it is sized for the longer of the two.
  localparam int CNT_MAX = (CONV_LAT > PACK_LAT) ? CONV_LAT : PACK_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, CONV, INIT, ITER, PACK, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [31:0]      op_n, res_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      iter_idx <= '0;
      op_data  <= '0;
      result   <= '0;
    end else if (clk_en) begin
      state    <= state_n;
      cnt      <= cnt_n;
      iter_idx <= idx_n;
      op_data  <= op_n;
      result   <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = iter_idx;
    op_n    = op_data;
    res_n   = result;
    unique case (state)
      IDLE: if (start) begin
        op_n    = dataa;
        cnt_n   = '0;
        state_n = CONV;
      end
      CONV: if (cnt == CNT_W'(CONV_LAT - 1)) begin
        cnt_n   = '0;
        state_n = INIT;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      INIT: begin
        idx_n   = '0;
        state_n = ITER;
      end
      // The index stops at the last iteration and is cleared on the way out, so it never wraps.
      ITER: if (iter_idx == IDX_W'(ITERATIONS - 1)) begin
        idx_n   = '0;
        cnt_n   = '0;
        state_n = PACK;
      end else begin
        idx_n = iter_idx + IDX_W'(1);
      end
      PACK: if (cnt == CNT_W'(PACK_LAT - 1)) begin
        res_n   = pk_result;
        state_n = DONE;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the state register only, so inputs have no combinational path to them.
  // Freezing the state under clk_en=0 therefore also holds every output.
  assign busy    = (state != IDLE);
  assign init    = (state == INIT);
  assign iter_en = (state == ITER);
  assign done    = (state == DONE);

endmodule
